// File: rtl/host_seq_pkg.sv
// Shared types and constants for the host command sequencer: opcodes, FSM states,
// status bit positions, FrontPanel endpoint addresses and the multiplier step.
package host_seq_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_ADD   = 3'd1,
      OP_SUB   = 3'd2,
      OP_MUL   = 3'd3,
      OP_LDLED = 3'd4,
      OP_RDLED = 3'd5,
      OP_ILL6  = 3'd6,
      OP_ILL7  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_ARM      = 2'd0,
      ST_IDLE     = 2'd1,
      ST_EXEC     = 2'd2,
      ST_MUL_ITER = 2'd3
   } state_e;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_ERR      = 1;
   localparam int STAT_OVF      = 2;
   localparam int STAT_OP_LSB   = 8;
   localparam int STAT_CNT_LSB  = 16;
   localparam int STAT_DONE_TAG = 31;

   localparam logic [7:0] WIRE_OPERAND_A = 8'h00;
   localparam logic [7:0] WIRE_OPERAND_B = 8'h01;
   localparam logic [7:0] WIRE_CMD       = 8'h02;
   localparam logic [7:0] WIRE_RESULT    = 8'h20;
   localparam logic [7:0] WIRE_STATUS    = 8'h21;

   // One shift-add step: {hi, lo} holds the running partial product in hi and the
   // unconsumed multiplier bits in lo; the add carry is shifted back into bit 63.
   function automatic logic [63:0] mul_step(input logic [63:0] prod, input logic [31:0] mcand);
      logic [32:0] sum;
      sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
      return {sum, prod[31:1]};
   endfunction

endpackage

// File: rtl/seq_mul32.sv
// Iterative 32x32 shift-add multiplier; the first step is folded into the start cycle.
// Built only when HOST_SEQ_MUL_EN is defined.
`ifdef HOST_SEQ_MUL_EN
module seq_mul32
   import host_seq_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] product
);

   logic [31:0] mcand;
   logic [5:0]  remaining;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         mcand     <= '0;
         remaining <= '0;
         product   <= '0;
      end else if (start) begin
         busy      <= 1'b1;
         mcand     <= a;
         remaining <= 6'(MUL_CYCLES - 1);
         product   <= mul_step({32'd0, b}, a);
      end else if (busy) begin
         if (remaining == 6'd0) begin
            busy <= 1'b0;
         end else begin
            remaining <= remaining - 6'd1;
            product   <= mul_step(product, mcand);
         end
      end
   end

   // All MUL_CYCLES steps have been applied once the counter has drained.
   assign done = busy && (remaining == 6'd0);

endmodule
`endif

// File: rtl/host_op_sequencer.sv
// Host command sequencer with toggle-tag handshake, arithmetic ops and the shared LED counter.
// Define HOST_SEQ_MUL_EN to build the multi-cycle multiplier; otherwise MUL is an illegal opcode.
module host_op_sequencer
   import host_seq_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        button_n,
   input  logic [31:0] cmd_word,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic [31:0] result,
   output logic [31:0] status,
   output logic [7:0]  led
);

   if (MUL_CYCLES != 32) begin : g_bad_mul_cycles
      $error("host_op_sequencer: MUL_CYCLES must be 32");
   end

   state_e      state;
   op_e         op_q;
   op_e         cmd_op;
   logic        last_tag, tag_q, cmd_new;
   logic        busy, err, ovf, done_tag;
   logic [31:0] a_q, b_q;
   logic [7:0]  count;

   assign cmd_op  = op_e'(cmd_word[2:0]);
   assign cmd_new = (state == ST_IDLE) && (cmd_word[31] != last_tag);

`ifdef HOST_SEQ_MUL_EN
   logic        mul_start, mul_busy, mul_done;
   logic [63:0] mul_product;

   assign mul_start = cmd_new && (cmd_op == OP_MUL);

   seq_mul32 #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (operand_a),
      .b       (operand_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_ARM;
         last_tag <= 1'b0;
         tag_q    <= 1'b0;
         op_q     <= OP_NOP;
         a_q      <= '0;
         b_q      <= '0;
         result   <= '0;
         busy     <= 1'b0;
         err      <= 1'b0;
         ovf      <= 1'b0;
         done_tag <= 1'b0;
         count    <= '0;
      end else begin
         // A LDLED completing below overrides this tick update.
         if (tick) count <= button_n ? count + 8'd1 : count - 8'd1;

         case (state)
            ST_ARM: begin
               last_tag <= cmd_word[31];
               state    <= ST_IDLE;
            end
            ST_IDLE: begin
               if (cmd_new) begin
                  last_tag <= cmd_word[31];
                  tag_q    <= cmd_word[31];
                  op_q     <= cmd_op;
                  a_q      <= operand_a;
                  b_q      <= operand_b;
                  busy     <= 1'b1;
`ifdef HOST_SEQ_MUL_EN
                  state    <= (cmd_op == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
`else
                  state    <= ST_EXEC;
`endif
               end
            end
            ST_EXEC: begin
               err      <= 1'b0;
               ovf      <= 1'b0;
               case (op_q)
                  OP_NOP:   ;
                  OP_ADD:   {ovf, result} <= {1'b0, a_q} + {1'b0, b_q};
                  OP_SUB: begin
                     result <= a_q - b_q;
                     ovf    <= (a_q < b_q);
                  end
                  OP_LDLED: count  <= a_q[7:0];
                  OP_RDLED: result <= {24'd0, count};
                  default:  err    <= 1'b1;
               endcase
               done_tag <= tag_q;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
`ifdef HOST_SEQ_MUL_EN
            ST_MUL_ITER: begin
               if (mul_done || !mul_busy) begin
                  result   <= mul_product[31:0];
                  ovf      <= |mul_product[63:32];
                  err      <= 1'b0;
                  done_tag <= tag_q;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      status                           = '0;
      status[STAT_BUSY]                = busy;
      status[STAT_ERR]                 = err;
      status[STAT_OVF]                 = ovf;
      status[STAT_OP_LSB +: 3]         = op_q;
      status[STAT_CNT_LSB +: 8]        = count;
      status[STAT_DONE_TAG]            = done_tag;
   end

   assign led = ~count;

endmodule
